// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM state encoding,
// default baud divider and idle line level.
package uart_pkg;

  localparam int unsigned CLK_DIV_DEFAULT = 434;
  localparam int unsigned STATE_W         = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_GAP    = 3'd1;
  localparam logic [STATE_W-1:0] ST_START  = 3'd2;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd3;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd4;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd5;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud divider: counts 0..CLK_DIV-1 while running, held at 0 by clr.
// bit_end is a registered single-cycle strobe in the last cycle of each bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int unsigned    CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLK_DIV - 2);

  logic [CNT_W-1:0] cnt;

  // bit_end is produced one cycle ahead so it lines up with cnt == LAST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt     <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      bit_end <= (cnt == PRE_LAST);
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops bytes from a FIFO and sends them 8N1 on tx.
// Define UART_TX_PARITY_EN to add an even parity bit after the payload.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = CLK_DIV_DEFAULT,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic                 enable,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned    BC_W      = $clog2(DATA_BITS);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);

  logic [STATE_W-1:0]   state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [BC_W-1:0]      bit_cnt, bit_cnt_n;
  logic                 tx_n, busy_n, rd_en_n;
  logic                 bit_end;
  logic                 baud_clr;
  logic                 pop_ok;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_n;
`endif

  assign baud_clr = (state == ST_IDLE) || (state == ST_GAP);
  assign pop_ok   = enable && !fifo_empty;

  uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      tx         <= IDLE_LEVEL;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      bit_cnt    <= bit_cnt_n;
      tx         <= tx_n;
      busy       <= busy_n;
      fifo_rd_en <= rd_en_n;
`ifdef UART_TX_PARITY_EN
      par        <= par_n;
`endif
    end
  end

  // The pop strobe is decided one cycle early (idle, or the last stop cycle)
  // so that the registered fifo_rd_en is high during the IDLE pop cycle.
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    tx_n      = tx;
    busy_n    = busy;
    rd_en_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n     = par;
`endif
    case (state)
      ST_IDLE: begin
        tx_n = IDLE_LEVEL;
        if (fifo_rd_en) begin
          state_n = ST_GAP;
          shift_n = fifo_dout;
`ifdef UART_TX_PARITY_EN
          par_n   = 1'b0;
`endif
        end else if (pop_ok) begin
          rd_en_n = 1'b1;
          busy_n  = 1'b1;
        end else begin
          busy_n  = 1'b0;
        end
      end
      // FIFO flag/data are stale here, so nothing is sampled
      ST_GAP: begin
        state_n   = ST_START;
        tx_n      = 1'b0;
        bit_cnt_n = '0;
      end
      ST_START: begin
        if (bit_end) begin
          state_n = ST_DATA;
          tx_n    = shift[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
`ifdef UART_TX_PARITY_EN
          par_n   = par ^ shift[0];
`endif
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n   = ST_PARITY;
            tx_n      = par ^ shift[0];
`else
            state_n   = ST_STOP;
            tx_n      = 1'b1;
`endif
          end else begin
            bit_cnt_n = bit_cnt + BC_W'(1);
            tx_n      = shift_n[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_n = ST_STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
            rd_en_n   = pop_ok;
            busy_n    = pop_ok;
          end else begin
            bit_cnt_n = bit_cnt + BC_W'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = IDLE_LEVEL;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
